ldst_pipe_unit: RTL and testbench

//  Parametrised load/store stage between Ex and Writeback with a real data-memory handshake.
//  Non-memory ops pass through in 1 cycle; stores retire at once into a DEPTH-entry store buffer

---
 rtl/ldst_pipe_unit.sv | 211 +++++++++++++++++++++
 tb/tb_ldst_pipe_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldst_pipe_unit.sv
// Load/store stage between Ex and Writeback with a background-draining store buffer.
// Ports: i_clk/i_rst_n, Ex inputs (i_valid..i_tag), o_stall, Writeback outputs, memory request/response.
module ldst_pipe_unit #(
  parameter int XLEN     = 64,
  parameter int SB_DEPTH = 4,
  parameter int TAG_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic [1:0]        i_op,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  input  logic [XLEN-1:0]   i_addr,
  input  logic [XLEN-1:0]   i_st_data,
  input  logic [TAG_W-1:0]  i_tag,
  output logic              o_stall,
  output logic              o_valid,
  output logic [TAG_W-1:0]  o_tag,
  output logic [XLEN-1:0]   o_data,
  output logic              o_misalign,
  output logic              o_mem_req_valid,
  input  logic              i_mem_req_ready,
  output logic              o_mem_req_we,
  output logic [XLEN-1:0]   o_mem_req_addr,
  output logic [XLEN-1:0]   o_mem_req_wdata,
  output logic [XLEN/8-1:0] o_mem_req_wmask,
  input  logic              i_mem_resp_valid,
  input  logic [XLEN-1:0]   i_mem_resp_data
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int PW   = $clog2(SB_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_DONE, S_DISC
  } state_t;

  state_t state, state_nx;

  logic              is_ld, is_st, mis;
  logic [OFFW-1:0]   off, amask;
  logic [NB-1:0]     smask;
  logic [XLEN-1:0]   waddr;

  logic [XLEN-1:0]   sb_addr [SB_DEPTH];
  logic [XLEN-1:0]   sb_data [SB_DEPTH];
  logic [NB-1:0]     sb_mask [SB_DEPTH];
  logic [SB_DEPTH-1:0] sb_vld;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       cnt;
  logic              full, empty, hazard, sb_pend;

  logic              idle_like, ld_go, start_load;
  logic              sb_req, pop, accept, enq;

  logic [XLEN-1:0]   ld_addr;
  logic [OFFW-1:0]   ld_off;
  logic [1:0]        ld_size;
  logic              ld_uns;
  logic [TAG_W-1:0]  ld_tag;
  logic [XLEN-1:0]   sh, keep, ld_res;
  logic              sgn;

  assign is_ld = (i_op == 2'b01);
  assign is_st = (i_op == 2'b10);
  assign off   = i_addr[OFFW-1:0];
  assign waddr = i_addr & ~XLEN'(NB - 1);

  always_comb begin
    amask = '0;
    smask = '0;
    unique case (i_size)
      2'd0: begin amask = OFFW'(0); smask = NB'(1);   end
      2'd1: begin amask = OFFW'(1); smask = NB'(3);   end
      2'd2: begin amask = OFFW'(3); smask = NB'(15);  end
      default: begin amask = OFFW'(7); smask = NB'(255); end
    endcase
  end

  assign mis = (is_ld | is_st) &
    (((XLEN == 32) && (i_size == 2'd3)) | (|(off & amask)));

  assign full  = (cnt == (PW+1)'(SB_DEPTH));
  assign empty = (cnt == '0);

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++)
      if (sb_vld[i] && (sb_addr[i] == waddr)) hazard = 1'b1;
  end

  assign idle_like  = (state == S_IDLE) || (state == S_DONE);
  assign ld_go      = idle_like & i_valid & is_ld & ~mis;
  // A store head already shown to memory must stay put, so it blocks a load.
  assign start_load = ld_go & ~hazard & ~sb_pend & ~i_flush;
  assign sb_req     = (state == S_IDLE) & ~empty & ~start_load;
  assign pop        = sb_req & i_mem_req_ready;

  assign o_stall = ~idle_like
                 | (ld_go & (hazard | sb_pend))
                 | (i_valid & is_st & ~mis & full & ~pop);

  assign accept = i_valid & ~o_stall & ~i_flush;
  assign enq    = accept & is_st & ~mis;

  assign o_mem_req_valid = (state == S_REQ) | sb_req;
  assign o_mem_req_we    = sb_req;
  assign o_mem_req_addr  = (state == S_REQ) ? ld_addr :
                           sb_req ? sb_addr[rd_ptr] : '0;
  assign o_mem_req_wdata = sb_req ? sb_data[rd_ptr] : '0;
  assign o_mem_req_wmask = sb_req ? sb_mask[rd_ptr] : '0;

  assign sh = i_mem_resp_data >> {ld_off, 3'b000};

  always_comb begin
    keep = '1;
    sgn  = 1'b0;
    unique case (ld_size)
      2'd0: begin keep = XLEN'(64'hFF);        sgn = sh[7];  end
      2'd1: begin keep = XLEN'(64'hFFFF);      sgn = sh[15]; end
      2'd2: begin keep = XLEN'(64'hFFFF_FFFF); sgn = sh[31]; end
      default: begin keep = '1; sgn = 1'b0; end
    endcase
  end

  assign ld_res = (sh & keep) | (~keep & {XLEN{sgn & ~ld_uns}});

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE:
        state_nx = start_load ? S_REQ : S_IDLE;
      S_REQ:
        if (i_flush) state_nx = S_IDLE;
        else if (i_mem_req_ready) state_nx = S_WAIT;
      S_WAIT:
        if (i_mem_resp_valid) state_nx = i_flush ? S_IDLE : S_DONE;
        else if (i_flush) state_nx = S_DISC;
      S_DISC:
        if (i_mem_resp_valid) state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (enq) begin
      sb_addr[wr_ptr] <= waddr;
      sb_data[wr_ptr] <= i_st_data << {off, 3'b000};
      sb_mask[wr_ptr] <= smask << off;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      sb_pend    <= 1'b0;
      sb_vld     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      ld_addr    <= '0;
      ld_off     <= '0;
      ld_size    <= '0;
      ld_uns     <= 1'b0;
      ld_tag     <= '0;
      o_valid    <= 1'b0;
      o_misalign <= 1'b0;
      o_tag      <= '0;
      o_data     <= '0;
    end else begin
      state   <= state_nx;
      sb_pend <= sb_req & ~i_mem_req_ready;
      cnt     <= cnt + (PW+1)'(enq) - (PW+1)'(pop);
      // Clear before set: when full, pop and enqueue share one slot.
      if (pop) begin
        sb_vld[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + 1'b1;
      end
      if (enq) begin
        sb_vld[wr_ptr] <= 1'b1;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (start_load) begin
        ld_addr <= waddr;
        ld_off  <= off;
        ld_size <= i_size;
        ld_uns  <= i_unsigned;
        ld_tag  <= i_tag;
      end
      o_valid    <= 1'b0;
      o_misalign <= 1'b0;
      if (!i_flush) begin
        if (state == S_WAIT && i_mem_resp_valid) begin
          o_valid <= 1'b1;
          o_tag   <= ld_tag;
          o_data  <= ld_res;
        end else if (accept && !start_load) begin
          o_valid    <= 1'b1;
          o_tag      <= i_tag;
          o_misalign <= mis;
          o_data     <= (mis || is_st) ? '0 : i_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_ldst_pipe_unit.sv
// Directed self-checking bench for ldst_pipe_unit (XLEN=64, SB_DEPTH=4).
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_ldst_pipe_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_flush;
  logic        i_valid;
  logic [1:0]  i_op;
  logic [1:0]  i_size;
  logic        i_unsigned;
  logic [63:0] i_addr;
  logic [63:0] i_st_data;
  logic [7:0]  i_tag;
  logic        o_stall;
  logic        o_valid;
  logic [7:0]  o_tag;
  logic [63:0] o_data;
  logic        o_misalign;
  logic        o_mem_req_valid;
  logic        i_mem_req_ready;
  logic        o_mem_req_we;
  logic [63:0] o_mem_req_addr;
  logic [63:0] o_mem_req_wdata;
  logic [7:0]  o_mem_req_wmask;
  logic        i_mem_resp_valid;
  logic [63:0] i_mem_resp_data;

  int errs = 0;
  int checks = 0;

  logic [63:0] sa [5];
  logic [1:0]  ssz [5];
  logic [63:0] sd [5];
  logic [63:0] ea [5];
  logic [7:0]  em [5];
  logic [63:0] ew [5];

  ldst_pipe_unit #(.XLEN(64), .SB_DEPTH(4), .TAG_W(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_valid(i_valid), .i_op(i_op), .i_size(i_size),
    .i_unsigned(i_unsigned), .i_addr(i_addr),
    .i_st_data(i_st_data), .i_tag(i_tag),
    .o_stall(o_stall), .o_valid(o_valid), .o_tag(o_tag),
    .o_data(o_data), .o_misalign(o_misalign),
    .o_mem_req_valid(o_mem_req_valid),
    .i_mem_req_ready(i_mem_req_ready),
    .o_mem_req_we(o_mem_req_we),
    .o_mem_req_addr(o_mem_req_addr),
    .o_mem_req_wdata(o_mem_req_wdata),
    .o_mem_req_wmask(o_mem_req_wmask),
    .i_mem_resp_valid(i_mem_resp_valid),
    .i_mem_resp_data(i_mem_resp_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic mid();
    @(negedge i_clk);
  endtask

  initial begin
    sa[0] = 64'h101; ssz[0] = 2'd0; sd[0] = 64'hAB;
    sa[1] = 64'h10A; ssz[1] = 2'd1; sd[1] = 64'h1234;
    sa[2] = 64'h114; ssz[2] = 2'd2; sd[2] = 64'hDEADBEEF;
    sa[3] = 64'h118; ssz[3] = 2'd3; sd[3] = 64'h0123456789ABCDEF;
    sa[4] = 64'h120; ssz[4] = 2'd0; sd[4] = 64'h55;
    ea[0] = 64'h100; em[0] = 8'h02; ew[0] = 64'hAB00;
    ea[1] = 64'h108; em[1] = 8'h0C; ew[1] = 64'h12340000;
    ea[2] = 64'h110; em[2] = 8'hF0; ew[2] = 64'hDEADBEEF_00000000;
    ea[3] = 64'h118; em[3] = 8'hFF; ew[3] = 64'h0123456789ABCDEF;
    ea[4] = 64'h120; em[4] = 8'h01; ew[4] = 64'h55;

    i_rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0;
    i_op = 2'd0; i_size = 2'd0; i_unsigned = 1'b0;
    i_addr = '0; i_st_data = '0; i_tag = '0;
    i_mem_req_ready = 1'b0; i_mem_resp_valid = 1'b0;
    i_mem_resp_data = '0;
    cyc(); cyc(); mid();
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_data", o_data, 64'd0);
    chk("rst_stall", 64'(o_stall), 64'd0);
    chk("rst_req", 64'(o_mem_req_valid), 64'd0);
    chk("rst_mis", 64'(o_misalign), 64'd0);
    cyc(); i_rst_n = 1'b1;

    // pass op
    cyc(); i_valid = 1'b1; i_op = 2'd0; i_addr = 64'h1234; i_tag = 8'd5;
    mid(); chk("pass_stall", 64'(o_stall), 64'd0);
    cyc(); i_valid = 1'b0;
    mid();
    chk("pass_valid", 64'(o_valid), 64'd1);
    chk("pass_data", o_data, 64'h1234);
    chk("pass_tag", 64'(o_tag), 64'd5);
    chk("pass_req", 64'(o_mem_req_valid), 64'd0);

    // input ignored under flush
    cyc(); i_valid = 1'b1; i_op = 2'd3; i_addr = 64'h77; i_tag = 8'd6;
    i_flush = 1'b1;
    cyc(); i_valid = 1'b0; i_flush = 1'b0;
    mid(); chk("flush_drop", 64'(o_valid), 64'd0);

    // reserved op behaves as pass
    cyc(); i_valid = 1'b1; i_op = 2'd3; i_addr = 64'h55; i_tag = 8'd7;
    cyc(); i_valid = 1'b0;
    mid();
    chk("rsv_valid", 64'(o_valid), 64'd1);
    chk("rsv_data", o_data, 64'h55);

    // signed byte load, minimum latency
    i_mem_req_ready = 1'b1;
    cyc(); i_valid = 1'b1; i_op = 2'd1; i_size = 2'd0; i_unsigned = 1'b0;
    i_addr = 64'h1003; i_tag = 8'd9;
    mid(); chk("ldb_acc", 64'(o_stall), 64'd0);
    cyc(); i_valid = 1'b0;
    mid();
    chk("ldb_req", 64'(o_mem_req_valid), 64'd1);
    chk("ldb_we", 64'(o_mem_req_we), 64'd0);
    chk("ldb_addr", o_mem_req_addr, 64'h1000);
    chk("ldb_stall", 64'(o_stall), 64'd1);
    cyc(); i_mem_resp_valid = 1'b1; i_mem_resp_data = 64'h80000000;
    mid(); chk("ldb_wait", 64'(o_valid), 64'd0);
    cyc(); i_mem_resp_valid = 1'b0;
    mid();
    chk("ldb_valid", 64'(o_valid), 64'd1);
    chk("ldb_data", o_data, 64'hFFFF_FFFF_FFFF_FF80);
    chk("ldb_tag", 64'(o_tag), 64'd9);
    chk("ldb_nostall", 64'(o_stall), 64'd0);

    // store buffer fill, full stall, in-order drain
    i_mem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(); i_valid = 1'b1; i_op = 2'd2; i_size = ssz[k];
      i_addr = sa[k]; i_st_data = sd[k]; i_tag = 8'(16 + k);
      mid(); chk("st_acc", 64'(o_stall), 64'd0);
    end
    cyc(); i_size = ssz[4]; i_addr = sa[4]; i_st_data = sd[4];
    i_tag = 8'd20;
    mid();
    chk("st_full", 64'(o_stall), 64'd1);
    chk("st_valid", 64'(o_valid), 64'd1);
    chk("st_data0", o_data, 64'd0);
    chk("st_tag", 64'(o_tag), 64'd19);
    chk("st_hold", o_mem_req_addr, 64'h100);
    cyc(); mid(); chk("st_full2", 64'(o_stall), 64'd1);
    cyc(); i_mem_req_ready = 1'b1;
    mid(); chk("st_popenq", 64'(o_stall), 64'd0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        cyc(); i_valid = 1'b0;
        mid();
      end
      if (k == 1) chk("st4_tag", 64'(o_tag), 64'd20);
      chk("drn_req", 64'(o_mem_req_valid), 64'd1);
      chk("drn_we", 64'(o_mem_req_we), 64'd1);
      chk("drn_addr", o_mem_req_addr, ea[k]);
      chk("drn_mask", 64'(o_mem_req_wmask), 64'(em[k]));
      chk("drn_wdata", o_mem_req_wdata, ew[k]);
    end
    cyc(); mid(); chk("drn_empty", 64'(o_mem_req_valid), 64'd0);

    // load-vs-store hazard
    i_mem_req_ready = 1'b0;
    cyc(); i_valid = 1'b1; i_op = 2'd2; i_size = 2'd2;
    i_addr = 64'h2000; i_st_data = 64'h11223344; i_tag = 8'd30;
    mid(); chk("hz_st", 64'(o_stall), 64'd0);
    cyc(); i_op = 2'd1; i_unsigned = 1'b1; i_addr = 64'h2004;
    i_tag = 8'd31;
    mid();
    chk("hz_stall", 64'(o_stall), 64'd1);
    chk("hz_addr", o_mem_req_addr, 64'h2000);
    chk("hz_we", 64'(o_mem_req_we), 64'd1);
    cyc(); mid(); chk("hz_stall2", 64'(o_stall), 64'd1);
    cyc(); i_mem_req_ready = 1'b1;
    mid();
    chk("hz_pop", 64'(o_stall), 64'd1);
    chk("hz_popreq", 64'(o_mem_req_valid), 64'd1);
    cyc(); mid();
    chk("hz_clear", 64'(o_stall), 64'd0);
    chk("hz_noreq", 64'(o_mem_req_valid), 64'd0);
    cyc(); i_valid = 1'b0;
    mid();
    chk("hz_ldreq", 64'(o_mem_req_valid), 64'd1);
    chk("hz_ldwe", 64'(o_mem_req_we), 64'd0);
    chk("hz_ldaddr", o_mem_req_addr, 64'h2000);
    cyc(); i_mem_resp_valid = 1'b1;
    i_mem_resp_data = 64'hAABBCCDD_11223344;
    cyc(); i_mem_resp_valid = 1'b0;
    mid();
    chk("hz_valid", 64'(o_valid), 64'd1);
    chk("hz_data", o_data, 64'h00000000_AABBCCDD);
    chk("hz_tag", 64'(o_tag), 64'd31);

    // flush while waiting, stale response discarded
    cyc(); i_valid = 1'b1; i_op = 2'd1; i_size = 2'd3;
    i_addr = 64'h3000; i_tag = 8'd40;
    cyc(); i_valid = 1'b0;
    mid(); chk("fl_req", 64'(o_mem_req_valid), 64'd1);
    cyc(); i_flush = 1'b1;
    mid(); chk("fl_wait", 64'(o_stall), 64'd1);
    cyc(); i_flush = 1'b0;
    mid();
    chk("fl_disc", 64'(o_stall), 64'd1);
    chk("fl_noval", 64'(o_valid), 64'd0);
    cyc(); i_mem_resp_valid = 1'b1; i_mem_resp_data = 64'hDEAD;
    mid(); chk("fl_absorb", 64'(o_stall), 64'd1);
    cyc(); i_mem_resp_valid = 1'b0;
    i_valid = 1'b1; i_op = 2'd1; i_size = 2'd3;
    i_addr = 64'h3008; i_tag = 8'd41;
    mid();
    chk("fl_noval2", 64'(o_valid), 64'd0);
    chk("fl_idle", 64'(o_stall), 64'd0);
    cyc(); i_valid = 1'b0;
    mid(); chk("fl_req2", o_mem_req_addr, 64'h3008);
    cyc(); i_mem_resp_valid = 1'b1;
    i_mem_resp_data = 64'h0BADF00D_CAFEBABE;
    cyc(); i_mem_resp_valid = 1'b0;
    mid();
    chk("fl_valid", 64'(o_valid), 64'd1);
    chk("fl_data", o_data, 64'h0BADF00D_CAFEBABE);
    chk("fl_tag", 64'(o_tag), 64'd41);

    // misaligned half load
    cyc(); i_valid = 1'b1; i_op = 2'd1; i_size = 2'd1;
    i_addr = 64'h1001; i_tag = 8'd50;
    mid(); chk("mis_acc", 64'(o_stall), 64'd0);
    cyc(); i_valid = 1'b0;
    mid();
    chk("mis_valid", 64'(o_valid), 64'd1);
    chk("mis_flag", 64'(o_misalign), 64'd1);
    chk("mis_noreq", 64'(o_mem_req_valid), 64'd0);
    chk("mis_tag", 64'(o_tag), 64'd50);
    cyc(); mid();
    chk("mis_clr", 64'(o_misalign), 64'd0);
    chk("mis_noreq2", 64'(o_mem_req_valid), 64'd0);

    // asynchronous reset drops buffered store
    i_mem_req_ready = 1'b0;
    cyc(); i_valid = 1'b1; i_op = 2'd2; i_size = 2'd0;
    i_addr = 64'h400; i_st_data = 64'h9;
    cyc(); i_valid = 1'b0;
    mid(); chk("ar_req", 64'(o_mem_req_valid), 64'd1);
    #1 i_rst_n = 1'b0;
    #1;
    chk("ar_req0", 64'(o_mem_req_valid), 64'd0);
    chk("ar_val0", 64'(o_valid), 64'd0);
    cyc(); cyc(); i_rst_n = 1'b1;
    cyc(); mid();
    chk("ar_lost", 64'(o_mem_req_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
